cbc_ctrl: RTL and testbench

Sequencer that runs a shared AES block core in CBC mode over a multi-block message. It accepts a per-message configuration (direction, IV, block count), pulls 128-bit blocks over a valid/ready stream, and issues one core operation per block. It applies the CBC pre-XOR (encryption) or post-XOR (decryption), maintains the chaining IV, and emits result blocks over a valid/ready stream. It sits between the AXI-stream packetizer and the AES round core.

---
 rtl/cbc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cbc_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbc_ctrl.sv
// -----------------------------------------------------------------------------
// cbc_ctrl
//   Runs a shared AES block core in CBC mode over a multi-block message.
//   A message is configured once (direction, IV, block count). Blocks are then
//   pulled one at a time, sent to the core, chained, and pushed out. Only one
//   block is in flight at a time.
//
//   Encrypt: core_in  = in_data ^ iv,   out = core_out,      iv' = core_out
//   Decrypt: core_in  = in_data,        out = core_out ^ iv, iv' = in_data
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cfg_valid/ready     message configuration handshake (ready only in IDLE)
//   cfg_encrypt         1 = CBC encrypt, 0 = CBC decrypt
//   cfg_iv              initial chaining value
//   cfg_nblocks         number of blocks in the message (0 is dropped)
//   in_valid/ready      input block handshake, in_data carries the block
//   core_start          one-cycle start pulse to the AES core
//   core_encrypt        direction to the core, stable for the whole message
//   core_in             registered block presented to the core
//   core_done/core_out  one-cycle core completion and its result
//   out_valid/ready     output block handshake, out_data carries the block
//   iv_out              current chaining IV (final IV once back in IDLE)
//   busy                high whenever a message is in progress
// -----------------------------------------------------------------------------
module cbc_ctrl #(
  parameter int BLK_W = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  // configuration
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_encrypt,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic [CNT_W-1:0] cfg_nblocks,
  // input block stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  // AES core
  output logic             core_start,
  output logic             core_encrypt,
  output logic [BLK_W-1:0] core_in,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_out,
  // output block stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  // status
  output logic [BLK_W-1:0] iv_out,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_START,
    S_WAIT_CORE,
    S_OUTPUT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  // Input block of the current operation; becomes the next IV when decrypting.
  logic [BLK_W-1:0] prev_in;

  // Every output is a register updated alongside the state, so the handshake
  // flags always agree with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too, not just the control
      // state: the block must come out of reset with every output at zero and
      // must not leak the IV or data of an aborted message.
      state        <= S_IDLE;
      cfg_ready    <= 1'b1;
      in_ready     <= 1'b0;
      core_start   <= 1'b0;
      core_encrypt <= 1'b0;
      core_in      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      iv_out       <= '0;
      busy         <= 1'b0;
      remaining    <= '0;
      prev_in      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values and the order of the statements below is
      // irrelevant to the result.
      case (state)
        S_IDLE: begin
          // A zero-length message still completes the handshake but is
          // otherwise dropped; iv_out keeps the previous message's final IV.
          if (cfg_valid && (cfg_nblocks != '0)) begin
            core_encrypt <= cfg_encrypt;
            iv_out       <= cfg_iv;
            remaining    <= cfg_nblocks;
            cfg_ready    <= 1'b0;
            busy         <= 1'b1;
            in_ready     <= 1'b1;
            state        <= S_WAIT_IN;
          end
        end

        S_WAIT_IN: begin
          if (in_valid) begin
            prev_in    <= in_data;
            core_in    <= core_encrypt ? (in_data ^ iv_out) : in_data;
            in_ready   <= 1'b0;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          // core_done is not looked at here: a completion in the same cycle
          // as the start pulse cannot belong to this operation.
          core_start <= 1'b0;
          state      <= S_WAIT_CORE;
        end

        S_WAIT_CORE: begin
          if (core_done) begin
            if (core_encrypt) begin
              out_data <= core_out;
              iv_out   <= core_out;
            end else begin
              out_data <= core_out ^ iv_out;
              iv_out   <= prev_in;
            end
            out_valid <= 1'b1;
            state     <= S_OUTPUT;
          end
        end

        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              cfg_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              in_ready  <= 1'b1;
              state     <= S_WAIT_IN;
            end
          end
        end

        default: begin
          cfg_ready  <= 1'b1;
          in_ready   <= 1'b0;
          core_start <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cbc_ctrl
//   Directed bench for cbc_ctrl. A behavioural core answers every start after
//   10 cycles. It uses a known-answer table for the AES-128 vectors (key
//   2b7e151628aed2a6abf7158809cf4f3c) and a simple invertible stand-in cipher
//   for any other block. Expected core inputs and output blocks come from a
//   CBC model evaluated over whole messages. They are queued and compared by
//   a single monitor running on the falling edge.
// -----------------------------------------------------------------------------
module tb_cbc_ctrl;

  localparam int BLK_W = 128;
  localparam int CNT_W = 16;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  // AES-128 input blocks that produce C1/C2 in CBC (P1^IV0, P2^C1).
  localparam logic [127:0] A1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] A2  = 128'hd86421fb9f1a1eda505ee1375746972c;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid, cfg_ready, cfg_encrypt;
  logic [BLK_W-1:0] cfg_iv;
  logic [CNT_W-1:0] cfg_nblocks;
  logic             in_valid, in_ready;
  logic [BLK_W-1:0] in_data;
  logic             core_start, core_encrypt, core_done;
  logic [BLK_W-1:0] core_in, core_out;
  logic             out_valid, out_ready;
  logic [BLK_W-1:0] out_data, iv_out;
  logic             busy;

  // Core model drives *_m, directed spurious pulses drive *_x.
  logic             core_done_m = 1'b0, core_done_x = 1'b0;
  logic [BLK_W-1:0] core_out_m = '0, core_out_x = '0;
  bit               core_auto = 1'b1;
  assign core_done = core_done_m | core_done_x;
  assign core_out  = core_done_x ? core_out_x : core_out_m;

  int checks = 0;
  int failures = 0;

  logic [127:0] exp_core_in[$];
  logic [127:0] exp_out[$];
  logic [127:0] exp_iv;
  logic [127:0] blk [0:3];
  logic [127:0] got [0:3];

  cbc_ctrl #(.BLK_W(BLK_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_encrypt(cfg_encrypt),
    .cfg_iv(cfg_iv), .cfg_nblocks(cfg_nblocks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_encrypt(core_encrypt), .core_in(core_in),
    .core_done(core_done), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .iv_out(iv_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in block cipher: known-answer AES pairs, otherwise rotate+xor.
  function automatic logic [127:0] core_enc(input logic [127:0] x);
    if (x == A1) return C1;
    if (x == A2) return C2;
    return {x[119:0], x[127:120]} ^ KEY;
  endfunction

  function automatic logic [127:0] core_dec(input logic [127:0] y);
    logic [127:0] t;
    if (y == C1) return A1;
    if (y == C2) return A2;
    t = y ^ KEY;
    return {t[7:0], t[127:8]};
  endfunction

  // Behavioural AES core: result 10 cycles after the start pulse.
  initial begin
    int           cnt;
    logic [127:0] cin;
    bit           dir;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      core_done_m = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done_m = 1'b1;
          core_out_m  = dir ? core_enc(cin) : core_dec(cin);
        end
      end else if (core_start && core_auto) begin
        cin = core_in;
        dir = core_encrypt;
        cnt = 10;
      end
    end
  end

  // Monitor: core inputs and output blocks against the queued model results,
  // output stability under backpressure, and busy/cfg_ready agreement.
  initial begin
    logic         prev_wait;
    logic [127:0] prev_data;
    prev_wait = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_wait = 1'b0;
      end else begin
        check("busy_vs_cfg_ready", busy, !cfg_ready);
        if (core_start) begin
          if (exp_core_in.size() == 0) check("unexpected_core_start", 1, 0);
          else check("core_in", core_in, exp_core_in.pop_front());
        end
        if (out_valid && prev_wait) check("out_data_stable", out_data, prev_data);
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) check("unexpected_output", 1, 0);
          else check("out_data", out_data, exp_out.pop_front());
        end
        prev_wait = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Run one message over blk[0..n-1]; results land in got[]. bp_blk holds
  // out_ready low 5 cycles on that block; junk_blk pulses cfg_valid and
  // core_done while that block is awaited.
  task automatic run_msg(input bit enc, input logic [127:0] iv, input int n,
                         input int bp_blk, input int junk_blk);
    logic [127:0] m_iv, ci, r, hold;
    int           budget;
    m_iv = iv;
    for (int i = 0; i < n; i++) begin
      if (enc) begin
        ci = blk[i] ^ m_iv; r = core_enc(ci); m_iv = r;
      end else begin
        ci = blk[i]; r = core_dec(ci) ^ m_iv; m_iv = blk[i];
      end
      exp_core_in.push_back(ci);
      exp_out.push_back(r);
    end
    exp_iv = m_iv;

    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_encrypt = enc; cfg_iv = iv; cfg_nblocks = CNT_W'(n);
    tick();
    cfg_valid = 1'b0; cfg_encrypt = ~enc; cfg_iv = '1;
    check("in_ready_after_cfg", in_ready, 1);

    for (int i = 0; i < n; i++) begin
      budget = 20;
      while (!in_ready && budget > 0) begin tick(); budget--; end
      if (!in_ready) begin check("in_ready_timeout", 0, 1); return; end

      if (i == junk_blk) begin
        cfg_valid = 1'b1; cfg_encrypt = ~enc; cfg_iv = 128'hdeadbeef;
        cfg_nblocks = 16'd7;
        core_done_x = 1'b1; core_out_x = 128'h0123456789abcdef;
        tick();
        cfg_valid = 1'b0; core_done_x = 1'b0;
        check("junk_in_ready_held", in_ready, 1);
        check("junk_no_out_valid", out_valid, 0);
      end

      in_valid = 1'b1; in_data = blk[i];
      tick();
      in_valid = 1'b0; in_data = '0;
      check("core_start_after_in", core_start, 1);
      check("core_encrypt", core_encrypt, enc);

      budget = 40;
      while (!out_valid && budget > 0) begin tick(); budget--; end
      if (!out_valid) begin check("out_valid_timeout", 0, 1); return; end

      if (i == bp_blk) begin
        hold = out_data;
        for (int k = 0; k < 5; k++) begin
          tick();
          check("bp_out_valid", out_valid, 1);
          check("bp_out_data", out_data, hold);
          check("bp_no_core_start", core_start, 0);
          check("bp_no_in_ready", in_ready, 0);
        end
      end

      got[i] = out_data;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("one_block_consumed", out_valid, 0);
    end
    check("end_cfg_ready", cfg_ready, 1);
    check("end_busy", busy, 0);
    check("end_iv_out", iv_out, exp_iv);
    check("end_queue_empty", exp_out.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    reset = 1'b1;
    cfg_valid = 1'b0; cfg_encrypt = 1'b0; cfg_iv = '0; cfg_nblocks = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_core_in", core_in, 0);
    check("rst_out_data", out_data, 0);
    check("rst_iv_out", iv_out, 0);
    check("rst_core_encrypt", core_encrypt, 0);
    reset = 1'b0;
    tick();

    // Encrypt, 2 blocks, backpressure on the first output.
    blk[0] = P1; blk[1] = P2;
    run_msg(1'b1, IV0, 2, 0, -1);
    check("enc_blk0_kat", got[0], C1);
    check("enc_blk1_kat", got[1], C2);
    check("enc_iv_kat", iv_out, C2);

    // Decrypt, same vectors.
    blk[0] = C1; blk[1] = C2;
    run_msg(1'b0, IV0, 2, -1, -1);
    check("dec_blk0_kat", got[0], P1);
    check("dec_blk1_kat", got[1], P2);
    check("dec_iv_kat", iv_out, C2);

    // Zero-length message is dropped; spurious done in IDLE is ignored.
    cfg_valid = 1'b1; cfg_encrypt = 1'b1; cfg_iv = 128'h55; cfg_nblocks = '0;
    core_done_x = 1'b1; core_out_x = 128'habcd;
    tick();
    cfg_valid = 1'b0; core_done_x = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("zero_busy", busy, 0);
      check("zero_no_core_start", core_start, 0);
      check("zero_no_out_valid", out_valid, 0);
      check("zero_iv_kept", iv_out, C2);
      tick();
    end

    // 3-block encrypt with junk cfg and spurious done mid-message, then a
    // 3-block decrypt continuing the chain from iv_out.
    blk[0] = 128'h00112233445566778899aabbccddeeff;
    blk[1] = 128'hffffffff000000001111111122222222;
    blk[2] = 128'h0;
    run_msg(1'b1, 128'hcafef00d, 3, -1, 1);
    run_msg(1'b0, iv_out, 3, 2, 0);

    // Reset in WAIT_CORE of block 1 of 3; core_done arrives afterwards.
    core_auto = 1'b0;
    exp_core_in.push_back(P1 ^ IV0);
    cfg_valid = 1'b1; cfg_encrypt = 1'b1; cfg_iv = IV0; cfg_nblocks = 16'd3;
    tick();
    cfg_valid = 1'b0;
    in_valid = 1'b1; in_data = P1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    core_done_x = 1'b1; core_out_x = C1;
    tick();
    core_done_x = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("abort_no_out_valid", out_valid, 0);
      check("abort_cfg_ready", cfg_ready, 1);
      check("abort_in_ready", in_ready, 0);
      tick();
    end
    check("abort_iv_cleared", iv_out, 0);
    check("abort_core_in_queue", exp_core_in.size(), 0);
    exp_out.delete();
    exp_core_in.delete();
    core_auto = 1'b1;

    // 1-block encrypt after the abort.
    blk[0] = P1;
    run_msg(1'b1, IV0, 1, -1, -1);
    check("post_abort_kat", got[0], C1);

    budget = 3;
    while (budget > 0) begin tick(); budget--; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
